mv_stream_host: RTL and testbench
=================================

Name: mv_stream_host

Overview:
- Host-side sequencer for the matrix-vector MAC engine.
- Streams vector x in from AXI-Stream and writes it to the x BRAM.
- Optionally zeroes y, then drives the engine's start/ack handshake (its ps_control/pl_status pair) as initiator.
- Reads y back out of the y BRAM onto AXI-Stream.
- Owns port B of the true-dual-port x and y BRAMs; the engine uses port A. Phases are disjoint, so there is no concurrent access. W is loaded by the PS, not by this block.

Parameters:
- addr_x_size, 12, x BRAM byte-address width
- addr_y_size, 12, y BRAM byte-address width
- length_M, 128, y length in 32-bit words
- length_N, 128, x length in 32-bit words

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset; 0 forces the block to IDLE immediately
- s_axis_tdata  in  32  x word (fp32)
- s_axis_tvalid  in  1  input beat valid
- s_axis_tlast  in  1  marks final x word
- s_axis_tready  out  1  input beat accepted
- m_axis_tdata  out  32  y word (fp32)
- m_axis_tvalid  out  1  output beat valid
- m_axis_tlast  out  1  marks word length_M-1
- m_axis_tready  in  1  downstream ready
- acc_control  out  32  to engine ps_control; bit0 = start, other bits 0
- acc_status  in  32  from engine pl_status; bit0 = done
- bram_addr_x  out  addr_x_size  x port-B byte address
- bram_wrdata_x  out  32  x write data
- bram_we_x  out  4  x byte enables
- bram_addr_y  out  addr_y_size  y port-B byte address
- bram_wrdata_y  out  32  y write data
- bram_rddata_y  in  32  y read data; 1-cycle latency after address
- bram_we_y  out  4  y byte enables
- busy  out  1  high in any state except IDLE
- err_tlast  out  1  sticky tlast-mismatch flag

Behaviour:
- Reset (reset=0, async): state=IDLE; both address counters=0; all outputs 0, including acc_control, m_axis_tvalid, err_tlast and busy.
- Reset asserted mid-operation: acc_control drops immediately. The engine finishes or resets on its own; the bench must also reset the engine.
- Addresses are byte addresses and step by 4. The word counter is separate; the address equals word*4.
- IDLE: s_axis_tready=0. On s_axis_tvalid=1, go to LOAD_X with x_addr=0 and err_tlast cleared.
- LOAD_X: s_axis_tready=1.
  - Write data: bram_wrdata_x=s_axis_tdata and bram_addr_x=x_addr (combinational).
  - On each handshake: bram_we_x=4'hf, otherwise 4'h0.
  - x_addr+=4 per beat.
  - On beat N-1 go to CLEAR_Y, or to START if the feature is off.
  - tlast on a beat other than N-1, or missing on beat N-1, sets err_tlast. Early tlast is otherwise ignored; exactly length_N beats are always consumed.
- CLEAR_Y: see Optional Feature.
- START: acc_control=1 for one cycle, then go to WAIT_DONE.
- WAIT_DONE: acc_control stays 1. When acc_status[0]=1, go to ACK.
- ACK: acc_control=0. Wait for acc_status[0]=0, then go to READ_ISSUE with y_addr=0.
- READ_ISSUE: bram_addr_y=y_addr is stable for this cycle; go to READ_CAP.
- READ_CAP: capture bram_rddata_y into the m_axis_tdata register; m_axis_tlast=(word==M-1); go to SEND.
- SEND: m_axis_tvalid=1, with tdata/tlast held stable until ready.
  - On tvalid&tready with the last word: go to IDLE.
  - On tvalid&tready otherwise: y_addr+=4 and go to READ_ISSUE.
  - Peak rate is 1 word per 3 cycles.
- bram_we_y=0 outside CLEAR_Y. bram_wrdata_y=0.
- No new input is accepted until the last y word has been sent; s_axis_tready=0 outside LOAD_X.
- The engine handshake has no timeout; WAIT_DONE waits indefinitely.

Optional Feature:
- Macro: MV_CLEAR_Y_EN.
- Defined: the CLEAR_Y state exists.
  - Writes 0 to y words 0..M-1, one per cycle: bram_we_y=4'hf, bram_wrdata_y=0.
  - Takes M cycles, then goes to START.
  - Reason: the engine accumulates into y, so y must start at 0.
- Undefined: LOAD_X goes directly to START. The PS must zero y before each run.

Test Plan:
- Reset mid-WAIT_DONE (reset=0 pulse) -> acc_control=0, busy=0 and m_axis_tvalid=0 asynchronously, before the next clk edge.
- Stream x=1.0 (32'h3F800000) ×128 with tlast on beat 127, no stalls -> 128 writes at addresses 0..508 step 4, err_tlast=0, START pulse follows. With MV_CLEAR_Y_EN, 128 zero-writes to y occur first.
- Engine model raises acc_status[0] 20 cycles after start -> acc_control falls the next cycle. Engine drops status -> first READ_ISSUE follows, with bram_addr_y=0.
- y BRAM preloaded with word k = k; m_axis_tready toggles 1/0 each cycle -> 128 beats in order 0..127, data stable while stalled, tlast only on the beat of value 127.
- tlast asserted on beat 63 -> err_tlast=1, yet exactly 128 beats consumed and the flow completes. err_tlast clears at the next IDLE->LOAD_X entry.
- s_axis_tvalid gaps of 3 cycles between beats -> bram_we_x high only on handshake cycles, addresses contiguous.

Source files
------------

// File: rtl/mv_stream_host.sv
// Host-side sequencer for the matrix-vector MAC engine: x in over AXI-Stream, engine start/ack,
// y out over AXI-Stream. Define MV_CLEAR_Y_EN to zero the y BRAM before each engine start.
`timescale 1ns/1ps
module mv_stream_host #(
  parameter int unsigned addr_x_size = 12,
  parameter int unsigned addr_y_size = 12,
  parameter int unsigned length_M    = 128,
  parameter int unsigned length_N    = 128
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic [31:0]            s_axis_tdata,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  output logic                   s_axis_tready,

  output logic [31:0]            m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,

  output logic [31:0]            acc_control,
  input  logic [31:0]            acc_status,

  output logic [addr_x_size-1:0] bram_addr_x,
  output logic [31:0]            bram_wrdata_x,
  output logic [3:0]             bram_we_x,

  output logic [addr_y_size-1:0] bram_addr_y,
  output logic [31:0]            bram_wrdata_y,
  input  logic [31:0]            bram_rddata_y,
  output logic [3:0]             bram_we_y,

  output logic                   busy,
  output logic                   err_tlast
);

  localparam int unsigned XcW = $clog2(length_N + 1);
  localparam int unsigned YcW = $clog2(length_M + 1);
  localparam logic [XcW-1:0] XLast = XcW'(length_N - 1);
  localparam logic [YcW-1:0] YLast = YcW'(length_M - 1);
  localparam logic [addr_x_size-1:0] XStep = addr_x_size'(4);
  localparam logic [addr_y_size-1:0] YStep = addr_y_size'(4);

  typedef enum logic [3:0] {
    StIdle,
    StLoadX,
    StClearY,
    StStart,
    StWaitDone,
    StAck,
    StReadIssue,
    StReadCap,
    StSend
  } state_e;

  state_e                 state_q, state_d;
  logic [addr_x_size-1:0] x_addr_q, x_addr_d;
  logic [XcW-1:0]         x_word_q, x_word_d;
  logic [addr_y_size-1:0] y_addr_q, y_addr_d;
  logic [YcW-1:0]         y_word_q, y_word_d;
  logic [31:0]            tdata_q, tdata_d;
  logic                   tlast_q, tlast_d;
  logic                   err_q, err_d;
  logic                   x_hs;
  logic                   x_last_beat;
  logic                   unused_status;

  // Only bit0 of the engine status word carries meaning.
  assign unused_status = ^acc_status[31:1];

  assign x_hs        = (state_q == StLoadX) && s_axis_tvalid;
  assign x_last_beat = (x_word_q == XLast);

  always_comb begin
    state_d  = state_q;
    x_addr_d = x_addr_q;
    x_word_d = x_word_q;
    y_addr_d = y_addr_q;
    y_word_d = y_word_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    err_d    = err_q;

    unique case (state_q)
      StIdle: begin
        if (s_axis_tvalid) begin
          state_d  = StLoadX;
          x_addr_d = '0;
          x_word_d = '0;
          err_d    = 1'b0;
        end
      end

      StLoadX: begin
        if (x_hs) begin
          x_addr_d = x_addr_q + XStep;
          x_word_d = x_word_q + 1'b1;
          // Beat count, not tlast, ends the load; a misplaced or missing tlast is only flagged.
          if (x_last_beat != s_axis_tlast) begin
            err_d = 1'b1;
          end
          if (x_last_beat) begin
`ifdef MV_CLEAR_Y_EN
            state_d  = StClearY;
            y_addr_d = '0;
            y_word_d = '0;
`else
            state_d  = StStart;
`endif
          end
        end
      end

`ifdef MV_CLEAR_Y_EN
      StClearY: begin
        if (y_word_q == YLast) begin
          state_d = StStart;
        end else begin
          y_addr_d = y_addr_q + YStep;
          y_word_d = y_word_q + 1'b1;
        end
      end
`endif

      StStart: begin
        state_d = StWaitDone;
      end

      StWaitDone: begin
        if (acc_status[0]) begin
          state_d = StAck;
        end
      end

      StAck: begin
        if (!acc_status[0]) begin
          state_d  = StReadIssue;
          y_addr_d = '0;
          y_word_d = '0;
        end
      end

      StReadIssue: begin
        state_d = StReadCap;
      end

      StReadCap: begin
        tdata_d = bram_rddata_y;
        tlast_d = (y_word_q == YLast);
        state_d = StSend;
      end

      StSend: begin
        if (m_axis_tready) begin
          if (tlast_q) begin
            state_d = StIdle;
          end else begin
            y_addr_d = y_addr_q + YStep;
            y_word_d = y_word_q + 1'b1;
            state_d  = StReadIssue;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      x_addr_q <= '0;
      x_word_q <= '0;
      y_addr_q <= '0;
      y_word_q <= '0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_addr_q <= x_addr_d;
      x_word_q <= x_word_d;
      y_addr_q <= y_addr_d;
      y_word_q <= y_word_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      err_q    <= err_d;
    end
  end

  // Outputs decode from the state register so an async reset clears them immediately.
  assign s_axis_tready = (state_q == StLoadX);
  assign bram_addr_x   = x_addr_q;
  assign bram_wrdata_x = (state_q == StLoadX) ? s_axis_tdata : 32'h0;
  assign bram_we_x     = x_hs ? 4'hf : 4'h0;

  assign bram_addr_y   = y_addr_q;
  assign bram_wrdata_y = 32'h0;
`ifdef MV_CLEAR_Y_EN
  assign bram_we_y     = (state_q == StClearY) ? 4'hf : 4'h0;
`else
  assign bram_we_y     = 4'h0;
`endif

  assign acc_control   = {31'h0, (state_q == StStart) || (state_q == StWaitDone)};

  assign m_axis_tvalid = (state_q == StSend);
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;

  assign busy          = (state_q != StIdle);
  assign err_tlast     = err_q;

endmodule

// File: tb/tb_mv_stream_host.sv
// Scoreboard bench for mv_stream_host: random x streams, a behavioural engine and y BRAM,
// and a monitor that checks every BRAM write and every output beat against queued expectations.
`timescale 1ns/1ps
module tb_mv_stream_host;

  localparam int unsigned M = 128;
  localparam int unsigned N = 128;
`ifdef MV_CLEAR_Y_EN
  localparam int unsigned ClrWords = M;
`else
  localparam int unsigned ClrWords = 0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic [31:0] acc_control;
  logic [31:0] acc_status;
  logic [11:0] bram_addr_x;
  logic [31:0] bram_wrdata_x;
  logic [3:0]  bram_we_x;
  logic [11:0] bram_addr_y;
  logic [31:0] bram_wrdata_y;
  logic [31:0] bram_rddata_y;
  logic [3:0]  bram_we_y;
  logic        busy;
  logic        err_tlast;

  mv_stream_host #(
    .addr_x_size(12),
    .addr_y_size(12),
    .length_M   (M),
    .length_N   (N)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .acc_control  (acc_control),
    .acc_status   (acc_status),
    .bram_addr_x  (bram_addr_x),
    .bram_wrdata_x(bram_wrdata_x),
    .bram_we_x    (bram_we_x),
    .bram_addr_y  (bram_addr_y),
    .bram_wrdata_y(bram_wrdata_y),
    .bram_rddata_y(bram_rddata_y),
    .bram_we_y    (bram_we_y),
    .busy         (busy),
    .err_tlast    (err_tlast)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk_eq(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Scoreboard queues and run bookkeeping
  logic [11:0] xa_q[$];
  logic [31:0] xd_q[$];
  logic [31:0] yd_q[$];
  logic        yl_q[$];
  int          x_wr_cnt;
  int          clr_cnt;
  int          beats;
  int          x_last_cyc;
  int          rdy_mode;
  int          y_mode;
  bit          eng_en;

  // y BRAM: port B (DUT) with 1-cycle read latency, port A bulk-loaded by the engine model
  logic [31:0] ymem [1024];
  logic [31:0] eng_y [M];
  logic        eng_load;

  always @(posedge clk) begin
    if (bram_we_y != 4'h0) ymem[bram_addr_y[11:2]] <= bram_wrdata_y;
    if (eng_load) begin
      for (int k = 0; k < int'(M); k++) ymem[k] <= eng_y[k];
    end
    bram_rddata_y <= ymem[bram_addr_y[11:2]];
  end

  // Engine model: writes its result into y, then runs the done/ack handshake
  initial begin
    acc_status = 32'h0;
    eng_load   = 1'b0;
    forever begin
      @(negedge clk);
      if (eng_en && acc_control[0] === 1'b1) begin
        chk_eq("start_latency", cyc - x_last_cyc, 1 + ClrWords);
        repeat (20) @(negedge clk);
        chk_eq("wait_done_ctrl", acc_control, 32'h1);
        for (int k = 0; k < int'(M); k++) begin
          logic [31:0] v;
          v = (y_mode == 0) ? k : $urandom;
          eng_y[k] = v;
          yd_q.push_back(v);
          yl_q.push_back(k == int'(M) - 1);
        end
        eng_load   = 1'b1;
        acc_status = 32'h1;
        @(negedge clk);
        eng_load = 1'b0;
        chk_eq("ack_ctrl_fall", acc_control, 32'h0);
        repeat ($urandom_range(1, 4)) @(negedge clk);
        acc_status = 32'h0;
      end
    end
  end

  // Downstream ready: toggling or random
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(negedge clk);
      if (rdy_mode == 0) m_axis_tready = ~m_axis_tready;
      else               m_axis_tready = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: samples 2ns after the falling edge, after the drivers have settled
  logic        m_stall = 1'b0;
  logic [31:0] h_data;
  logic        h_last;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (bram_we_x !== 4'h0) begin
        x_wr_cnt++;
        if (xd_q.size() == 0) begin
          chk_eq("x_queue_depth", xd_q.size(), 1);
        end else begin
          chk_eq("x_we", bram_we_x, 4'hf);
          chk_eq("x_addr", bram_addr_x, xa_q.pop_front());
          chk_eq("x_data", bram_wrdata_x, xd_q.pop_front());
        end
      end
      if (bram_we_y !== 4'h0) begin
        chk_eq("y_clr_we", bram_we_y, 4'hf);
        chk_eq("y_clr_addr", bram_addr_y, clr_cnt * 4);
        chk_eq("y_clr_data", bram_wrdata_y, 32'h0);
        clr_cnt++;
      end
      if (m_axis_tvalid === 1'b1) begin
        if (m_stall) begin
          chk_eq("y_hold_data", m_axis_tdata, h_data);
          chk_eq("y_hold_last", m_axis_tlast, h_last);
        end
        if (m_axis_tready) begin
          beats++;
          m_stall = 1'b0;
          if (yd_q.size() == 0) begin
            chk_eq("y_queue_depth", yd_q.size(), 1);
          end else begin
            chk_eq("y_data", m_axis_tdata, yd_q.pop_front());
            chk_eq("y_last", m_axis_tlast, yl_q.pop_front());
          end
        end else begin
          m_stall = 1'b1;
          h_data  = m_axis_tdata;
          h_last  = m_axis_tlast;
        end
      end else begin
        if (m_stall) chk_eq("y_valid_dropped", m_axis_tvalid, 1);
        m_stall = 1'b0;
      end
    end
  end

  // Streams N x words; gmode 0: none, 1: 3-cycle gaps, 2: random 0..2; bmode picks tlast pattern
  task automatic send_x(input int dmode, input int gmode, input int bmode, output bit exp_err);
    exp_err = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      logic [31:0] d;
      logic        tl;
      int          gap;
      int          g;
      d  = (dmode == 0) ? 32'h3F80_0000 : $urandom;
      tl = (k == int'(N) - 1);
      if (bmode == 1) tl = (k == 63) || (k == int'(N) - 1);
      else if (bmode == 2) tl = ($urandom_range(0, 15) == 0);
      if (tl != (k == int'(N) - 1)) exp_err = 1'b1;
      gap = (gmode == 1) ? 3 : (gmode == 2) ? $urandom_range(0, 2) : 0;
      if (k == 0) gap = 0;
      repeat (gap) begin
        @(negedge clk);
        s_axis_tvalid = 1'b0;
      end
      @(negedge clk);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tlast  = tl;
      g = 0;
      while (s_axis_tready !== 1'b1 && g < 500) begin
        @(negedge clk);
        g++;
      end
      if (s_axis_tready !== 1'b1) begin
        chk_eq("x_tready_timeout", s_axis_tready, 1);
        break;
      end
      if (k == 0) chk_eq("err_clear_on_load", err_tlast, 0);
      xa_q.push_back(12'(k * 4));
      xd_q.push_back(d);
      if (k == int'(N) - 1) x_last_cyc = cyc;
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic run(input int dmode, input int gmode, input int bmode, input int rmode,
                     input int ymode);
    bit exp_err;
    int t;
    rdy_mode = rmode;
    y_mode   = ymode;
    beats    = 0;
    x_wr_cnt = 0;
    clr_cnt  = 0;
    send_x(dmode, gmode, bmode, exp_err);
    t = 0;
    while (busy === 1'b1 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk_eq("run_done", busy, 0);
    @(negedge clk);
    #3;
    chk_eq("x_writes", x_wr_cnt, N);
    chk_eq("y_beats", beats, M);
    chk_eq("y_clears", clr_cnt, ClrWords);
    chk_eq("err_tlast", err_tlast, exp_err);
    chk_eq("y_left", yd_q.size(), 0);
  endtask

  initial begin
    bit exp_err;
    int t;
    reset         = 1'b0;
    s_axis_tdata  = 32'h0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    eng_en        = 1'b1;
    rdy_mode      = 0;
    y_mode        = 0;
    x_last_cyc    = 0;
    for (int k = 0; k < 1024; k++) ymem[k] = 32'hdead_0000 + k;
    repeat (3) @(negedge clk);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_tready", s_axis_tready, 0);
    chk_eq("rst_tvalid", m_axis_tvalid, 0);
    chk_eq("rst_ctrl", acc_control, 0);
    chk_eq("rst_err", err_tlast, 0);
    chk_eq("rst_addr_x", bram_addr_x, 0);
    chk_eq("rst_addr_y", bram_addr_y, 0);
    chk_eq("rst_we_x", bram_we_x, 0);
    chk_eq("rst_we_y", bram_we_y, 0);
    reset = 1'b1;

    run(0, 0, 0, 0, 0);   // x = 1.0, no stalls, y[k] = k, tready toggling
    run(1, 1, 1, 1, 1);   // 3-cycle gaps, early tlast on beat 63
    run(1, 2, 2, 1, 1);   // random gaps, random tlast

    // Reset while the engine is holding off done
    eng_en   = 1'b0;
    rdy_mode = 1;
    x_wr_cnt = 0;
    clr_cnt  = 0;
    send_x(1, 0, 1, exp_err);
    t = 0;
    while (acc_control[0] !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk_eq("rst_test_start", acc_control, 1);
    repeat (5) @(negedge clk);
    chk_eq("pre_reset_err", err_tlast, exp_err);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk_eq("async_rst_ctrl", acc_control, 0);
    chk_eq("async_rst_busy", busy, 0);
    chk_eq("async_rst_tvalid", m_axis_tvalid, 0);
    chk_eq("async_rst_err", err_tlast, 0);
    @(negedge clk);
    #3;
    acc_status = 32'h0;
    reset      = 1'b1;
    eng_en     = 1'b1;

    run(1, 0, 0, 0, 1);   // recovery after reset

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1);
  end

endmodule
